// File: rtl/logic_unit_pkg.sv
// rtl/logic_unit_pkg.sv - op encodings and flag bit positions for logic_unit
// Contents:
//   OP_AND..OP_PASS  3-bit op select codes
//   FLAG_*           bit positions inside the 3-bit flags vector
package logic_unit_pkg;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_NOR  = 3'd2;
  localparam logic [2:0] OP_NAND = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;
  localparam logic [2:0] OP_NOT  = 3'd6;
  localparam logic [2:0] OP_PASS = 3'd7;

  localparam int FLAG_ZERO     = 0;
  localparam int FLAG_ALL_ONES = 1;
  localparam int FLAG_PARITY   = 2;

endpackage

// File: rtl/logic_unit_core.sv
// rtl/logic_unit_core.sv - combinational bitwise op and result flags
// Ports:
//   a, b    [WIDTH-1:0]  operands (b unused by NOT/PASS)
//   op      [2:0]        op select
//   result  [WIDTH-1:0]  bitwise result
//   flags   [2:0]        {parity, all_ones, zero} of result
module logic_unit_core
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] result,
  output logic [2:0]       flags
);

  always_comb begin
    result = '0;
    case (op)
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_NOR:  result = ~(a | b);
      OP_NAND: result = ~(a & b);
      OP_XOR:  result = a ^ b;
      OP_XNOR: result = ~(a ^ b);
      OP_NOT:  result = ~a;
      OP_PASS: result = a;
      default: result = '0;
    endcase
  end

  always_comb begin
    flags                = '0;
    flags[FLAG_ZERO]     = (result == '0);
    flags[FLAG_ALL_ONES] = &result;
    flags[FLAG_PARITY]   = ^result;
  end

endmodule

// File: rtl/logic_unit.sv
// rtl/logic_unit.sv - bitwise logic unit with a single registered output stage
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   a, b, op, in_valid    input transaction; in_ready accepts it
//   y, flags, out_valid   registered result; out_ready drains it
//   txn_count [CNT_W-1:0] wrapping count of accepted transactions
module logic_unit
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] y,
  output logic [2:0]       flags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] txn_count
);

  logic [WIDTH-1:0] core_result;
  logic [2:0]       core_flags;
  logic             accept;

  logic_unit_core #(.WIDTH(WIDTH)) u_core (
    .a      (a),
    .b      (b),
    .op     (op),
    .result (core_result),
    .flags  (core_flags)
  );

  // The output register can take a new result when empty or when it is
  // being drained this same cycle; depends only on out_valid/out_ready.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y         <= '0;
      flags     <= '0;
      out_valid <= 1'b0;
      txn_count <= '0;
    end else begin
      if (accept) begin
        // Covers simultaneous drain+accept: out_valid stays high.
        y         <= core_result;
        flags     <= core_flags;
        out_valid <= 1'b1;
        txn_count <= txn_count + CNT_W'(1);
      end else if (out_ready) begin
        // Drain with nothing new: y/flags keep their last value.
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_logic_unit.sv
// tb/tb_logic_unit.sv - self-checking bench for logic_unit
module tb_logic_unit;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] ey;
    logic [2:0] ef;
  } vec_t;

  typedef struct {
    logic [7:0] y;
    logic [2:0] f;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] a, b;
  logic [2:0] op;
  logic       in_valid, out_ready;
  logic       in_ready, out_valid;
  logic [7:0] y;
  logic [2:0] flags;
  logic [15:0] txn_count;

  logic       in_ready4, out_valid4;
  logic [7:0] y4;
  logic [2:0] flags4;
  logic [3:0] txn_count4;

  int   n_pass = 0;
  int   n_total = 0;
  exp_t sb[$];
  logic m_ov;
  int   m_cnt;

  always #5 clk = ~clk;

  logic_unit #(.WIDTH(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .op(op), .in_valid(in_valid),
    .in_ready(in_ready), .y(y), .flags(flags), .out_valid(out_valid),
    .out_ready(out_ready), .txn_count(txn_count)
  );

  logic_unit #(.WIDTH(8), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .op(op), .in_valid(in_valid),
    .in_ready(in_ready4), .y(y4), .flags(flags4), .out_valid(out_valid4),
    .out_ready(out_ready), .txn_count(txn_count4)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  function automatic logic [7:0] ref_y(input logic [2:0] o, input logic [7:0] x, input logic [7:0] z);
    case (o)
      3'd0: return x & z;
      3'd1: return x | z;
      3'd2: return ~(x | z);
      3'd3: return ~(x & z);
      3'd4: return x ^ z;
      3'd5: return ~(x ^ z);
      3'd6: return ~x;
      default: return x;
    endcase
  endfunction

  function automatic logic [2:0] ref_f(input logic [7:0] r);
    return {^r, r == 8'hFF, r == 8'h00};
  endfunction

  // One clock cycle: drive just after a rising edge, check handshake mid-cycle,
  // then check registered state just after the next rising edge.
  task automatic cyc(input logic v, input logic [2:0] o, input logic [7:0] aa,
                     input logic [7:0] bb, input logic rdy,
                     input logic [7:0] ey, input logic [2:0] ef);
    logic exp_ready;
    exp_t e;
    in_valid = v; op = o; a = aa; b = bb; out_ready = rdy;
    #1;
    exp_ready = !m_ov || rdy;
    chk("in_ready", in_ready, exp_ready);
    if (m_ov && rdy) begin
      if (sb.size() == 0) begin
        chk("scoreboard_empty", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("drain_y", y, e.y);
        chk("drain_flags", flags, e.f);
      end
    end
    if (v && exp_ready) begin
      e.y = ey; e.f = ef;
      sb.push_back(e);
      m_cnt++;
      m_ov = 1'b1;
    end else if (rdy) begin
      m_ov = 1'b0;
    end
    @(posedge clk); #1;
    chk("out_valid", out_valid, m_ov);
    chk("txn_count", txn_count, 64'(m_cnt[15:0]));
    chk("txn_count4", txn_count4, 64'(m_cnt[3:0]));
  endtask

  task automatic cyc_ref(input logic v, input logic [2:0] o, input logic [7:0] aa,
                         input logic [7:0] bb, input logic rdy);
    logic [7:0] r;
    r = ref_y(o, aa, bb);
    cyc(v, o, aa, bb, rdy, r, ref_f(r));
  endtask

  task automatic do_reset(input logic v, input logic rdy);
    rst_n = 1'b0; in_valid = v; out_ready = rdy;
    op = 3'd7; a = 8'h55; b = 8'h00;
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb.delete(); m_ov = 1'b0; m_cnt = 0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_y", y, 0);
    chk("rst_flags", flags, 0);
    chk("rst_txn_count", txn_count, 0);
    chk("rst_in_ready", in_ready, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vt[12];
    vt[0]  = '{3'd2, 8'h0F, 8'h30, 8'hC0, 3'b000};
    vt[1]  = '{3'd4, 8'hA5, 8'hA5, 8'h00, 3'b001};
    vt[2]  = '{3'd3, 8'h00, 8'h00, 8'hFF, 3'b010};
    vt[3]  = '{3'd0, 8'hF0, 8'h3C, 8'h30, 3'b000};
    vt[4]  = '{3'd1, 8'h12, 8'h40, 8'h52, 3'b100};
    vt[5]  = '{3'd5, 8'h0F, 8'hF0, 8'h00, 3'b001};
    vt[6]  = '{3'd6, 8'h5A, 8'hFF, 8'hA5, 3'b000};
    vt[7]  = '{3'd7, 8'h01, 8'hFF, 8'h01, 3'b100};
    vt[8]  = '{3'd0, 8'hFF, 8'hFF, 8'hFF, 3'b010};
    vt[9]  = '{3'd6, 8'h00, 8'h12, 8'hFF, 3'b010};
    vt[10] = '{3'd1, 8'h00, 8'h00, 8'h00, 3'b001};
    vt[11] = '{3'd4, 8'h01, 8'h03, 8'h02, 3'b100};

    m_ov = 1'b0; m_cnt = 0;
    @(posedge clk); #1;
    do_reset(1'b0, 1'b0);

    // First transaction: single-cycle latency, count 1.
    cyc(1, vt[0].op, vt[0].a, vt[0].b, 1, vt[0].ey, vt[0].ef);
    chk("nor_y", y, 8'hC0);
    chk("nor_flags", flags, 3'b000);
    chk("nor_count", txn_count, 1);
    for (int i = 1; i < 12; i++)
      cyc(1, vt[i].op, vt[i].a, vt[i].b, 1, vt[i].ey, vt[i].ef);
    cyc_ref(0, 3'd0, 8'hFF, 8'hFF, 1);
    // Idle cycles with garbage inputs must not move anything.
    cyc_ref(0, 3'd3, 8'h00, 8'h00, 1);
    chk("idle_y_hold", y, 8'h02);
    chk("idle_flags_hold", flags, 3'b100);

    // Back-pressure: held result ignores new operands.
    cyc_ref(1, 3'd7, 8'h01, 8'h00, 0);
    for (int i = 0; i < 3; i++) begin
      cyc_ref(1, 3'd7, 8'(8'h10 + i), 8'h00, 0);
      chk("stall_y", y, 8'h01);
      chk("stall_flags", flags, 3'b100);
    end
    cyc_ref(0, 3'd0, 8'h00, 8'h00, 1);
    chk("stall_release_ov", out_valid, 0);

    // Streaming with ops cycling, no bubbles.
    do_reset(1'b0, 1'b1);
    for (int i = 0; i < 10; i++)
      cyc_ref(1, 3'(i % 8), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1);
    chk("stream_count", txn_count, 10);
    cyc_ref(0, 3'd0, 8'h00, 8'h00, 1);

    // Narrow counter wraps after 16 accepts.
    do_reset(1'b1, 1'b1);
    for (int i = 0; i < 17; i++)
      cyc_ref(1, 3'(i % 8), 8'(i * 7), 8'(i * 13), 1);
    chk("wrap_count4", txn_count4, 4'd1);
    chk("wrap_count16", txn_count, 17);
    cyc_ref(0, 3'd0, 8'h00, 8'h00, 1);

    // Reset during a stall discards the held result.
    cyc_ref(1, 3'd6, 8'h00, 8'h00, 0);
    cyc_ref(1, 3'd0, 8'hFF, 8'hFF, 0);
    do_reset(1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
